// File: rtl/voucher_scan_decoder_if.sv
// Scanner/controller bundle for voucher_scan_decoder.
// master: scanner + payment controller side; slave: the decoder.
interface voucher_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic                scan_start;
    logic                sym_valid;
    logic [3:0]          sym_data;
    logic                scan_busy;
    logic [4*DIGITS-1:0] voucher_id;
    logic                scan_done;
    logic                scan_error;
    logic [1:0]          err_code;

    modport master (
        output scan_start,
        output sym_valid,
        output sym_data,
        input  scan_busy,
        input  voucher_id,
        input  scan_done,
        input  scan_error,
        input  err_code
    );

    modport slave (
        input  scan_start,
        input  sym_valid,
        input  sym_data,
        output scan_busy,
        output voucher_id,
        output scan_done,
        output scan_error,
        output err_code
    );
endinterface

// File: rtl/voucher_scan_decoder.sv
// Nibble-serial voucher scan decoder: DIGITS data nibbles + XOR check digit.
// Ports: clk, reset_n (async low), bus (slave): start/symbol in, busy/id/done/error/err_code out.
module voucher_scan_decoder #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1000
) (
    input logic                   clk,
    input logic                   reset_n,
    voucher_scan_decoder_if.slave bus
);
    localparam int ID_W  = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 2);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // Symbol count at which the incoming symbol is the check digit.
    localparam logic [CNT_W-1:0] CHK_IDX  = CNT_W'(DIGITS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  shreg_q, shreg_d;
    logic [3:0]       xsum_q, xsum_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [1:0]       err_q, err_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        xsum_d  = xsum_q;
        tmr_d   = tmr_q;
        id_d    = id_q;
        err_d   = err_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        unique case (state_q)
            // The report cycle already counts as idle for scan_start,
            // so a new scan can begin on the edge right after the pulse.
            S_IDLE, S_REPORT: begin
                state_d = S_IDLE;
                if (bus.scan_start) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    shreg_d = '0;
                    xsum_d  = '0;
                    tmr_d   = '0;
                end
            end

            S_COLLECT: begin
                if (bus.sym_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    tmr_d = '0;
                    if (cnt_q == CHK_IDX) begin
                        state_d = S_REPORT;
                        if (bus.sym_data == xsum_q) begin
                            id_d   = shreg_q;
                            err_d  = 2'b00;
                            done_d = 1'b1;
                        end else begin
                            err_d   = 2'b01;
                            error_d = 1'b1;
                        end
                    end else begin
                        shreg_d = (shreg_q << 4) | ID_W'(bus.sym_data);
                        xsum_d  = xsum_q ^ bus.sym_data;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    // Partial ID in shreg is simply dropped.
                    state_d = S_REPORT;
                    err_d   = 2'b10;
                    error_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_COLLECT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            xsum_q  <= '0;
            tmr_q   <= '0;
            id_q    <= '0;
            err_q   <= 2'b00;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            xsum_q  <= xsum_d;
            tmr_q   <= tmr_d;
            id_q    <= id_d;
            err_q   <= err_d;
            done_q  <= done_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.scan_busy  = busy_q;
    assign bus.voucher_id = id_q;
    assign bus.scan_done  = done_q;
    assign bus.scan_error = error_q;
    assign bus.err_code   = err_q;

endmodule

// File: tb/tb_voucher_scan_decoder.sv
// Bench for voucher_scan_decoder: DIGITS=4 and DIGITS=8 instances, TIMEOUT=16.
// Scans are planned as symbol/gap lists; a transaction-level model predicts the outcome.
module tb_voucher_scan_decoder;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    logic [3:0] sym_q[$];
    int         gap_q[$];

    logic [31:0] m_id[2];
    logic [1:0]  m_err[2];

    voucher_scan_decoder_if #(.DIGITS(4)) b4 ();
    voucher_scan_decoder_if #(.DIGITS(8)) b8 ();

    voucher_scan_decoder #(.DIGITS(4), .TIMEOUT(TMO)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b4)
    );

    voucher_scan_decoder #(.DIGITS(8), .TIMEOUT(TMO)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_flags(input bit sel);
        return sel ? {29'd0, b8.scan_busy, b8.scan_done, b8.scan_error}
                   : {29'd0, b4.scan_busy, b4.scan_done, b4.scan_error};
    endfunction

    function automatic logic [31:0] get_id(input bit sel);
        return sel ? b8.voucher_id : {16'd0, b4.voucher_id};
    endfunction

    function automatic logic [31:0] get_err(input bit sel);
        return sel ? {30'd0, b8.err_code} : {30'd0, b4.err_code};
    endfunction

    task automatic drive(input bit sel, input bit st, input bit v,
                         input logic [3:0] d);
        b4.scan_start = sel ? 1'b0 : st;
        b4.sym_valid  = sel ? 1'b0 : v;
        b4.sym_data   = sel ? 4'h0 : d;
        b8.scan_start = sel ? st : 1'b0;
        b8.sym_valid  = sel ? v : 1'b0;
        b8.sym_data   = sel ? d : 4'h0;
    endtask

    // gap_q[i] = idle edges before symbol i (counted from E0 or the previous symbol).
    task automatic run_scan(input bit sel, input bit pre_stray, input bit mid_start);
        int          n;
        int          e;
        int          exp_edge;
        int          kind;
        logic [31:0] id;
        logic [3:0]  x;
        bit          sv[512];
        logic [3:0]  sd[512];
        logic [31:0] fl;

        n        = sel ? 8 : 4;
        e        = 0;
        exp_edge = -1;
        kind     = 0;
        id       = '0;
        x        = '0;
        for (int i = 0; i < 512; i++) begin
            sv[i] = 1'b0;
            sd[i] = 4'h0;
        end

        for (int i = 0; i < sym_q.size() && exp_edge < 0; i++) begin
            if (gap_q[i] >= TMO) begin
                exp_edge = e + TMO;
                kind     = 2;
            end else begin
                e     = e + gap_q[i] + 1;
                sv[e] = 1'b1;
                sd[e] = sym_q[i];
                if (i < n) begin
                    id = (id << 4) | {28'd0, sym_q[i]};
                    x  = x ^ sym_q[i];
                end else begin
                    exp_edge = e;
                    kind     = (sym_q[i] == x) ? 0 : 1;
                end
            end
        end
        if (exp_edge < 0) begin
            exp_edge = e + TMO;
            kind     = 2;
        end

        if (pre_stray) begin
            for (int i = 0; i < 3; i++) begin
                drive(sel, 1'b0, 1'b1, 4'($urandom));
                @(posedge clk);
                #1;
                check("idle_stray", get_flags(sel), 32'd0);
            end
        end

        drive(sel, 1'b1, pre_stray, 4'($urandom));
        for (int k = 0; k <= exp_edge + 1; k++) begin
            @(posedge clk);
            #1;
            if (k < exp_edge)
                fl = 32'd4;
            else if (k == exp_edge)
                fl = (kind == 0) ? 32'd2 : 32'd1;
            else
                fl = 32'd0;
            check("flags", get_flags(sel), fl);
            if (k == 0) begin
                check("id_hold", get_id(sel), m_id[sel]);
                check("err_hold", get_err(sel), {30'd0, m_err[sel]});
            end
            if (k == exp_edge) begin
                if (kind == 0)
                    m_id[sel] = id;
                m_err[sel] = 2'(kind);
                check("id", get_id(sel), m_id[sel]);
                check("err_code", get_err(sel), {30'd0, m_err[sel]});
            end
            drive(sel, mid_start && (k + 1 == 2), sv[k+1],
                  sv[k+1] ? sd[k+1] : 4'($urandom));
        end
        drive(sel, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic plan(input logic [3:0] s[], input int g[]);
        sym_q.delete();
        gap_q.delete();
        foreach (s[i]) begin
            sym_q.push_back(s[i]);
            gap_q.push_back(g[i]);
        end
    endtask

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return TMO - 1;
        if (r == 8) return TMO;
        return $urandom_range(4, TMO - 2);
    endfunction

    bit         rsel;
    int         rn;
    int         rns;
    logic [3:0] rx;
    logic [3:0] rd;

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        m_id[0]  = '0;
        m_id[1]  = '0;
        m_err[0] = '0;
        m_err[1] = '0;
        #1;
        check("rst_flags4", get_flags(1'b0), 32'd0);
        check("rst_id4", get_id(1'b0), 32'd0);
        check("rst_err8", get_err(1'b1), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        plan('{4'hA, 4'hB, 4'hC, 4'hD, 4'h0}, '{0, 0, 0, 0, 0});
        run_scan(1'b0, 1'b0, 1'b0);
        check("good_abcd", get_id(1'b0), 32'h0000ABCD);

        plan('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5}, '{0, 0, 0, 0, 0});
        run_scan(1'b0, 1'b0, 1'b0);
        check("chk_keep", get_id(1'b0), 32'h0000ABCD);

        plan('{4'h7, 4'h7}, '{0, 0});
        run_scan(1'b0, 1'b0, 1'b0);
        check("tmo_code", get_err(1'b0), 32'd2);

        plan('{4'h7, 4'h7, 4'h1, 4'h2, 4'h3}, '{0, 0, TMO - 1, 0, 0});
        run_scan(1'b0, 1'b0, 1'b0);
        check("late_sym", get_id(1'b0), 32'h00007712);

        plan('{4'h1, 4'h2, 4'h3, 4'h4, 4'h4}, '{5, 5, 5, 5, 5});
        run_scan(1'b0, 1'b1, 1'b1);
        check("gapped", get_id(1'b0), 32'h00001234);

        drive(1'b0, 1'b1, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1, 4'h1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1, 4'h2);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("pre_rst_busy", get_flags(1'b0), 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_flags", get_flags(1'b0), 32'd0);
        check("mid_rst_id", get_id(1'b0), 32'd0);
        check("mid_rst_err", get_err(1'b0), 32'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        m_id[0]  = '0;
        m_id[1]  = '0;
        m_err[0] = '0;
        m_err[1] = '0;
        @(posedge clk);
        #1;

        plan('{4'h9, 4'h8, 4'h7, 4'h6, 4'h0}, '{0, 0, 0, 0, 0});
        run_scan(1'b0, 1'b0, 1'b0);
        check("post_rst", get_id(1'b0), 32'h00009876);

        plan('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h8},
             '{0, 0, 0, 0, 0, 0, 0, 0, 0});
        run_scan(1'b1, 1'b0, 1'b0);
        check("good_d8", get_id(1'b1), 32'h12345678);

        for (int t = 0; t < 40; t++) begin
            rsel = 1'($urandom_range(0, 1));
            rn   = rsel ? 8 : 4;
            rns  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rn) : rn + 1;
            rx   = '0;
            sym_q.delete();
            gap_q.delete();
            for (int i = 0; i < rns; i++) begin
                rd = 4'($urandom);
                if (i == rn && $urandom_range(0, 1) == 1)
                    rd = rx;
                rx = rx ^ rd;
                sym_q.push_back(rd);
                gap_q.push_back(rand_gap());
            end
            run_scan(rsel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
